// File: rtl/bcd_converter_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock; done arrives WIDTH cycles after start is accepted.
// Optional active-low seven-segment decode of the result is compiled in with BCD_SEG7_EN.
module bcd_converter_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef BCD_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [AW-1:0]   acc, adj, acc_nxt;
    logic [CW-1:0]   cnt;
    logic            ovf_i, ovf_nxt;
    logic            armed;
    logic            accept, last;

    // armed stays low for the first edge after reset release, so a start
    // presented in the same cycle as the release is not taken.
    assign accept = (state == IDLE) && start && armed;
    assign last   = (state == SHIFT) && (cnt == CW'(1));
    assign busy   = (state == SHIFT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        adj = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
            end
        end
    end

    assign acc_nxt = {adj[AW-2:0], sreg[WIDTH-1]};
    assign ovf_nxt = ovf_i | adj[AW-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_i    <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            done  <= 1'b0;
            if (accept) begin
                sreg  <= bin;
                acc   <= '0;
                cnt   <= CW'(WIDTH);
                ovf_i <= 1'b0;
            end else if (state == SHIFT) begin
                sreg  <= sreg << 1;
                acc   <= acc_nxt;
                cnt   <= cnt - CW'(1);
                ovf_i <= ovf_nxt;
                if (last) begin
                    bcd      <= acc_nxt;
                    overflow <= ovf_nxt;
                    done     <= 1'b1;
                end
            end
        end
    end

`ifdef BCD_SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    for (genvar k = 0; k < DIGITS; k++) begin : g_seg
        assign seg[7*k +: 7] = seg7(bcd[4*k +: 4]);
    end
`endif

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Bench for bcd_converter_seq: a 16-bit/5-digit and an 8-bit/2-digit instance,
// directed vector tables, handshake corner cases and random operands against a decimal model.
module tb_bcd_converter_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_a, start_b;
    logic [15:0] bin_a;
    logic [7:0]  bin_b;
    logic        busy_a, done_a, ovf_a;
    logic        busy_b, done_b, ovf_b;
    logic [19:0] bcd_a;
    logic [7:0]  bcd_b;
`ifdef BCD_SEG7_EN
    logic [34:0] seg_a;
    logic [13:0] seg_b;
`endif

    always #5 clk = ~clk;

    bcd_converter_seq #(.WIDTH(16), .DIGITS(5)) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
`ifdef BCD_SEG7_EN
        , .seg(seg_a)
`endif
    );

    bcd_converter_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
`ifdef BCD_SEG7_EN
        , .seg(seg_b)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
    } vec_a_t;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] bcd;
        logic       ovf;
    } vec_b_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Decimal model: digits of v mod 10^digits, least significant first.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int digits);
        int unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return v >= p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input logic [15:0] v, input string name,
                         input logic [19:0] exp_bcd, input logic exp_ovf);
        int lat;
        int busy_cnt;
        lat = 0;
        busy_cnt = 0;
        start_a = 1'b1;
        bin_a   = v;
        tick();
        start_a = 1'b0;
        while (!done_a && lat < 40) begin
            if (busy_a) busy_cnt++;
            tick();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd16);
        check({name, " busy cycles"}, 32'(busy_cnt), 32'd16);
        check({name, " busy at done"}, 32'(busy_a), 32'd0);
        check({name, " bcd"}, 32'(bcd_a), 32'(exp_bcd));
        check({name, " overflow"}, 32'(ovf_a), 32'(exp_ovf));
        tick();
        check({name, " done one cycle"}, 32'(done_a), 32'd0);
    endtask

    task automatic run_b(input logic [7:0] v, input string name,
                         input logic [7:0] exp_bcd, input logic exp_ovf);
        int lat;
        lat = 0;
        start_b = 1'b1;
        bin_b   = v;
        tick();
        start_b = 1'b0;
        while (!done_b && lat < 30) begin
            tick();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd8);
        check({name, " bcd"}, 32'(bcd_b), 32'(exp_bcd));
        check({name, " overflow"}, 32'(ovf_b), 32'(exp_ovf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_a_t va[8];
        vec_b_t vb[5];
        int gap;
        int nd;
        logic [15:0] r16;
        logic [7:0]  r8;

        va = '{
            '{16'd0,     20'h00000, 1'b0},
            '{16'd65535, 20'h65535, 1'b0},
            '{16'd1234,  20'h01234, 1'b0},
            '{16'd9,     20'h00009, 1'b0},
            '{16'd10,    20'h00010, 1'b0},
            '{16'd9999,  20'h09999, 1'b0},
            '{16'd10000, 20'h10000, 1'b0},
            '{16'd40960, 20'h40960, 1'b0}
        };
        vb = '{
            '{8'd255, 8'h55, 1'b1},
            '{8'd99,  8'h99, 1'b0},
            '{8'd100, 8'h00, 1'b1},
            '{8'd0,   8'h00, 1'b0},
            '{8'd128, 8'h28, 1'b1}
        };

        resetn  = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        bin_a   = '0;
        bin_b   = '0;
        tick();
        tick();
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset done", 32'(done_a), 32'd0);
        check("reset bcd", 32'(bcd_a), 32'd0);
        check("reset overflow", 32'(ovf_a), 32'd0);
        check("reset bcd b", 32'(bcd_b), 32'd0);
`ifdef BCD_SEG7_EN
        for (int k = 0; k < 5; k++) check("reset seg", 32'(seg_a[7*k +: 7]), 32'h40);
`endif
        resetn = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 8; i++) run_a(va[i].bin, "vec_a", va[i].bcd, va[i].ovf);
        for (int i = 0; i < 5; i++) run_b(vb[i].bin, "vec_b", vb[i].bcd, vb[i].ovf);

        run_a(16'd19, "nineteen", 20'h00019, 1'b0);
`ifdef BCD_SEG7_EN
        check("seg digit0", 32'(seg_a[6:0]),   32'h10);
        check("seg digit1", 32'(seg_a[13:7]),  32'h79);
        check("seg digit2", 32'(seg_a[20:14]), 32'h40);
`endif

        // Start held high: second operand is taken in the done cycle, so the
        // pulses are 16 shift cycles plus one idle cycle apart.
        start_a = 1'b1;
        bin_a   = 16'd1234;
        tick();
        bin_a = 16'd19;
        gap = 0;
        while (!done_a && gap < 40) begin
            tick();
            gap++;
        end
        check("b2b first bcd", 32'(bcd_a), 32'h01234);
        tick();
        gap = 1;
        check("b2b reaccept busy", 32'(busy_a), 32'd1);
        while (!done_a && gap < 40) begin
            tick();
            gap++;
        end
        start_a = 1'b0;
        check("b2b done spacing", 32'(gap), 32'd17);
        check("b2b second bcd", 32'(bcd_a), 32'h00019);
        tick();
        check("b2b idle after", 32'(busy_a), 32'd0);

        // Start pulse in the middle of a conversion must be ignored.
        start_a = 1'b1;
        bin_a   = 16'd500;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        start_a = 1'b1;
        bin_a   = 16'd7;
        tick();
        start_a = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_a) nd++;
            tick();
        end
        check("mid start done count", 32'(nd), 32'd1);
        check("mid start bcd", 32'(bcd_a), 32'h00500);

        // Reset during shift cycle 7 of a conversion.
        start_a = 1'b1;
        bin_a   = 16'd4321;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        resetn = 1'b0;
        #1;
        check("abort busy", 32'(busy_a), 32'd0);
        check("abort done", 32'(done_a), 32'd0);
        check("abort bcd", 32'(bcd_a), 32'd0);
        check("abort overflow", 32'(ovf_a), 32'd0);
`ifdef BCD_SEG7_EN
        check("abort seg", 32'(seg_a[6:0]), 32'h40);
`endif
        tick();
        resetn  = 1'b1;
        start_a = 1'b1;
        bin_a   = 16'd4321;
        tick();
        check("start at reset release ignored", 32'(busy_a), 32'd0);
        start_a = 1'b0;
        tick();
        run_a(16'd4321, "after abort", 20'h04321, 1'b0);

        for (int i = 0; i < 25; i++) begin
            r16 = 16'($urandom_range(0, 65535));
            run_a(r16, "rand_a", 20'(ref_bcd(32'(r16), 5)), ref_ovf(32'(r16), 5));
        end
        for (int i = 0; i < 20; i++) begin
            r8 = 8'($urandom_range(0, 255));
            run_b(r8, "rand_b", 8'(ref_bcd(32'(r8), 2)), ref_ovf(32'(r8), 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
